// File: rtl/panel_ctrl_if.sv
// rtl/panel_ctrl_if.sv - core request port and main-memory rw port seen by panel_ctrl
interface panel_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              core_val_i;
    logic              core_wen_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [DATA_W-1:0] core_wdata_i;
    logic              core_rdy_o;
    logic [DATA_W-1:0] core_rdata_o;
    logic              mem_val_o;
    logic              mem_wen_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_rdy_i;

    modport master (
        input  core_val_i, core_wen_i, core_addr_i, core_wdata_i, mem_rdata_i, mem_rdy_i,
        output core_rdy_o, core_rdata_o, mem_val_o, mem_wen_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output core_val_i, core_wen_i, core_addr_i, core_wdata_i, mem_rdata_i, mem_rdy_i,
        input  core_rdy_o, core_rdata_o, mem_val_o, mem_wen_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/panel_ctrl.sv
// rtl/panel_ctrl.sv - front-panel sequencer, button debounce and memory port arbiter
module panel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_load_i,
    input  logic              btn_look_i,
    input  logic              btn_step_i,
    input  logic              btn_run_i,
    input  logic              btn_stop_i,
    input  logic [ADDR_W-1:0] sw_addr_i,
    input  logic [DATA_W-1:0] sw_data_i,
    panel_ctrl_if.master      bus,
    output logic              cpu_exec_o,
    input  logic              instr_done_i,
    input  logic [DATA_W-1:0] instr_data_i,
    input  logic              halt_i,
    output logic              pc_wen_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              running_o,
    output logic [ADDR_W-1:0] disp_addr_o,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              led_ready_o
);
    localparam int CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int B_LOAD = 0;
    localparam int B_LOOK = 1;
    localparam int B_STEP = 2;
    localparam int B_RUN  = 3;
    localparam int B_STOP = 4;

    typedef enum logic [2:0] {IDLE, PANEL, STEP, RUN, STOPPING} state_t;

    state_t            state, next;
    logic [4:0]        raw, sync1, sync2, deb, press;
    logic [CW-1:0]     cnt [5];
    logic              op_wr, step_first;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              running, exec;
    logic              m_val, m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;

    assign raw = {btn_stop_i, btn_run_i, btn_step_i, btn_look_i, btn_load_i};

    // Any sample agreeing with the debounced level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            press <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 5; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i]   <= '0;
                    deb[i]   <= sync2[i];
                    press[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (press[B_STOP])                      next = IDLE;
                else if (press[B_RUN])                  next = RUN;
                else if (press[B_STEP])                 next = STEP;
                else if (press[B_LOAD] || press[B_LOOK]) next = PANEL;
            end
            PANEL:    if (bus.mem_rdy_i) next = IDLE;
            STEP:     if (instr_done_i)  next = IDLE;
            RUN: begin
                if (instr_done_i && halt_i) next = IDLE;
                else if (press[B_STOP])     next = STOPPING;
            end
            STOPPING: if (instr_done_i)  next = IDLE;
            default:  next = IDLE;
        endcase
    end

    always_comb begin
        running = (state == STEP) || (state == RUN) || (state == STOPPING);
        exec    = (state == RUN) || ((state == STEP) && step_first);
        m_val   = 1'b0;
        m_wen   = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (running) begin
            m_val   = bus.core_val_i;
            m_wen   = bus.core_wen_i;
            m_addr  = bus.core_addr_i;
            m_wdata = bus.core_wdata_i;
        end else if (state == PANEL) begin
            m_val   = 1'b1;
            m_wen   = op_wr;
            m_addr  = lat_addr;
            m_wdata = lat_data;
        end
    end

    assign bus.mem_val_o    = m_val;
    assign bus.mem_wen_o    = m_wen;
    assign bus.mem_addr_o   = m_addr;
    assign bus.mem_wdata_o  = m_wdata;
    assign bus.core_rdy_o   = running && bus.mem_rdy_i;
    assign bus.core_rdata_o = bus.mem_rdata_i;
    assign running_o        = running;
    assign cpu_exec_o       = exec;
    assign led_ready_o      = (state == IDLE);

    // A retiring instruction overrides the panel display update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr       <= 1'b0;
            lat_addr    <= '0;
            lat_data    <= '0;
            disp_addr_o <= '0;
            disp_data_o <= '0;
            pc_o        <= '0;
            pc_wen_o    <= 1'b0;
            step_first  <= 1'b0;
        end else begin
            pc_wen_o   <= 1'b0;
            step_first <= (state == IDLE) && (next == STEP);
            if ((state == IDLE) && (next == PANEL)) begin
                op_wr    <= press[B_LOAD];
                lat_addr <= sw_addr_i;
                lat_data <= sw_data_i;
            end
            if ((state == PANEL) && bus.mem_rdy_i) begin
                disp_addr_o <= lat_addr;
                disp_data_o <= op_wr ? lat_data : bus.mem_rdata_i;
                pc_o        <= lat_addr;
                pc_wen_o    <= 1'b1;
            end
            if (instr_done_i) disp_data_o <= instr_data_i;
        end
    end
endmodule

// File: tb/tb_panel_ctrl.sv
// tb/tb_panel_ctrl.sv - directed scoreboard bench for panel_ctrl
module tb_panel_ctrl;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  btn;
    logic [7:0]  sw_addr;
    logic [15:0] sw_data;
    logic        cpu_exec, instr_done, halt, pc_wen, running, led_ready;
    logic [15:0] instr_data, disp_data;
    logic [7:0]  pc, disp_addr;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   pulses;

    always #5 clk = ~clk;

    panel_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    panel_ctrl #(.DEBOUNCE_CYCLES(D), .ADDR_W(8), .DATA_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_load_i   (btn[0]),
        .btn_look_i   (btn[1]),
        .btn_step_i   (btn[2]),
        .btn_run_i    (btn[3]),
        .btn_stop_i   (btn[4]),
        .sw_addr_i    (sw_addr),
        .sw_data_i    (sw_data),
        .bus          (bus),
        .cpu_exec_o   (cpu_exec),
        .instr_done_i (instr_done),
        .instr_data_i (instr_data),
        .halt_i       (halt),
        .pc_wen_o     (pc_wen),
        .pc_o         (pc),
        .running_o    (running),
        .disp_addr_o  (disp_addr),
        .disp_data_o  (disp_data),
        .led_ready_o  (led_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i);
        btn[i] = 1'b1;
        repeat (D + 3) @(negedge clk);
    endtask

    task automatic release_btns();
        btn = '0;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic tick_count();
        @(negedge clk);
        if (pc_wen) pulses++;
    endtask

    task automatic wait_pc_wen(input string tag);
        exp_t e;
        bit   seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (pc_wen) seen = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_pc_wen_seen"}, seen, 1);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_disp_addr"}, disp_addr, e.addr);
            chk({tag, "_disp_data"}, disp_data, e.data);
            chk({tag, "_pc"}, pc, e.addr);
        end
    endtask

    task automatic retire(input string tag, input logic [15:0] data, input logic h);
        exp_t e;
        exp_q.push_back('{disp_addr, data});
        instr_data = data;
        halt       = h;
        instr_done = 1'b1;
        @(negedge clk);
        instr_done = 1'b0;
        halt       = 1'b0;
        chk({tag, "_ready"}, led_ready, 1);
        chk({tag, "_running"}, running, 0);
        e = exp_q.pop_front();
        chk({tag, "_disp_data"}, disp_data, e.data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; btn = '1; sw_addr = '0; sw_data = '0;
        instr_done = 1'b0; instr_data = '0; halt = 1'b0;
        bus.core_val_i = 1'b0; bus.core_wen_i = 1'b0; bus.core_addr_i = '0;
        bus.core_wdata_i = '0; bus.mem_rdata_i = '0; bus.mem_rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", led_ready, 1);
        chk("rst_mem_val", bus.mem_val_o, 0);
        chk("rst_exec", cpu_exec, 0);

        rst_n = 1'b1; btn = '0;
        pulses = 0;
        for (int k = 0; k < D + 6; k++) begin
            @(negedge clk);
            if (pc_wen || !led_ready || cpu_exec || running || bus.mem_val_o) pulses++;
        end
        chk("rst_quiet", pulses, 0);
        chk("rst_disp_addr", disp_addr, 0);
        chk("rst_disp_data", disp_data, 0);
        chk("rst_pc", pc, 0);
        chk("rst_core_rdy", bus.core_rdy_o, 0);
        bus.mem_rdata_i = 16'hA5A5;
        #1 chk("rst_core_rdata", bus.core_rdata_o, 16'hA5A5);

        push(4);
        chk("stop_idle_noop", led_ready, 1);
        release_btns();

        // LOAD with memory completing on the third held cycle
        sw_addr = 8'h10; sw_data = 16'hBEEF; bus.mem_rdy_i = 1'b0;
        exp_q.push_back('{8'h10, 16'hBEEF});
        btn[0] = 1'b1;
        repeat (D + 2) @(negedge clk);
        chk("load_latency_pre", bus.mem_val_o, 0);
        @(negedge clk);
        sw_data = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            chk("load_val", bus.mem_val_o, 1);
            chk("load_wen", bus.mem_wen_o, 1);
            chk("load_addr", bus.mem_addr_o, 8'h10);
            chk("load_wdata", bus.mem_wdata_o, 16'hBEEF);
            chk("load_no_pc_wen", pc_wen, 0);
            if (k == 2) bus.mem_rdy_i = 1'b1;
            @(negedge clk);
        end
        bus.mem_rdy_i = 1'b0;
        wait_pc_wen("load");
        chk("load_ready", led_ready, 1);
        release_btns();

        // LOOK, memory ready immediately
        sw_addr = 8'h10; bus.mem_rdata_i = 16'h1234; bus.mem_rdy_i = 1'b1;
        exp_q.push_back('{8'h10, 16'h1234});
        push(1);
        chk("look_val", bus.mem_val_o, 1);
        chk("look_wen", bus.mem_wen_o, 0);
        chk("look_addr", bus.mem_addr_o, 8'h10);
        @(negedge clk);
        chk("look_ready_n2", led_ready, 1);
        wait_pc_wen("look");
        release_btns();

        // bouncing LOOK button
        sw_addr = 8'h20; bus.mem_rdata_i = 16'h5555;
        pulses = 0;
        for (int b = 0; b < 5; b++) begin
            btn[1] = 1'b1;
            repeat (D / 2) tick_count();
            btn[1] = 1'b0;
            repeat (D / 2) tick_count();
        end
        btn[1] = 1'b1;
        repeat (3 * D) tick_count();
        chk("bounce_pulses", pulses, 1);
        chk("bounce_disp_addr", disp_addr, 8'h20);
        chk("bounce_disp_data", disp_data, 16'h5555);
        release_btns();

        // STEP with a core read
        bus.core_val_i = 1'b1; bus.core_wen_i = 1'b0; bus.core_addr_i = 8'h33;
        bus.mem_rdata_i = 16'hCAFE; bus.mem_rdy_i = 1'b1;
        push(2);
        chk("step_exec", cpu_exec, 1);
        chk("step_running", running, 1);
        chk("step_mem_val", bus.mem_val_o, 1);
        chk("step_mem_addr", bus.mem_addr_o, 8'h33);
        chk("step_mem_wen", bus.mem_wen_o, 0);
        chk("step_core_rdy", bus.core_rdy_o, 1);
        chk("step_core_rdata", bus.core_rdata_o, 16'hCAFE);
        chk("step_not_ready", led_ready, 0);
        @(negedge clk);
        chk("step_exec_once", cpu_exec, 0);
        chk("step_still_running", running, 1);
        retire("step", 16'h8A01, 1'b0);
        chk("step_idle_mem_val", bus.mem_val_o, 0);
        chk("step_idle_core_rdy", bus.core_rdy_o, 0);
        bus.core_val_i = 1'b0;
        release_btns();

        // RUN, ignored LOAD, then STOP with a core write outstanding
        bus.core_val_i = 1'b1; bus.core_wen_i = 1'b1; bus.core_addr_i = 8'h44;
        bus.core_wdata_i = 16'h7777; bus.mem_rdy_i = 1'b0;
        push(3);
        chk("run_exec", cpu_exec, 1);
        chk("run_running", running, 1);
        chk("run_mem_wen", bus.mem_wen_o, 1);
        chk("run_mem_addr", bus.mem_addr_o, 8'h44);
        chk("run_mem_wdata", bus.mem_wdata_o, 16'h7777);
        chk("run_core_rdy_wait", bus.core_rdy_o, 0);
        btn = '0;
        sw_addr = 8'h99;
        push(0);
        chk("run_load_ignored_exec", cpu_exec, 1);
        chk("run_load_ignored_pc_wen", pc_wen, 0);
        release_btns();
        push(4);
        chk("stopping_exec", cpu_exec, 0);
        chk("stopping_running", running, 1);
        chk("stopping_mem_val", bus.mem_val_o, 1);
        bus.mem_rdy_i = 1'b1;
        #1 chk("stopping_core_rdy", bus.core_rdy_o, 1);
        @(negedge clk);
        bus.mem_rdy_i = 1'b0; bus.core_val_i = 1'b0;
        chk("stopping_hold", running, 1);
        retire("stop", 16'h0001, 1'b0);
        chk("run_disp_addr_kept", disp_addr, 8'h20);
        release_btns();

        // RUN ended by HALT
        push(3);
        chk("run2_exec", cpu_exec, 1);
        btn = '0;
        repeat (2) @(negedge clk);
        retire("halt", 16'hF000, 1'b1);
        release_btns();

        // asynchronous reset in the middle of a panel write
        sw_addr = 8'h55; bus.mem_rdy_i = 1'b0;
        push(0);
        chk("mid_panel_val", bus.mem_val_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_val", bus.mem_val_o, 0);
        chk("async_rst_ready", led_ready, 1);
        chk("async_rst_exec", cpu_exec, 0);
        @(negedge clk);
        rst_n = 1'b1; btn = '0;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
